fetch_stage: RTL and testbench

- Upstream producer for the fetch/decode pipeline register. It owns the PC and runs a request/ready handshake to a variable-latency instruction memory.
- It presents PCounterF, PCPlus4F, InstrF and InstrValidF to the fetch/decode pipe.
- It obeys stallF and PC redirects (PCSrcE/PCTargetE) from execute.
- It raises fetch_busy so the hazard unit can drive flushD and insert a bubble while no instruction is ready.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_stage.sv | 113 +++++++++++
 tb/tb_fetch_stage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int PC_INCR = 4;

endpackage

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, fetches from a variable-latency instruction memory
// and presents one instruction at a time to the fetch/decode pipeline register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] PCounterF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic [DATA_WIDTH-1:0] InstrF,
  output logic                  InstrValidF,
  output logic                  fetch_busy,
  output logic [1:0]            state_dbg
);

  // Memory handshake: a transfer happens on a rising edge where imem_req and
  // imem_ready are both 1. Once raised, imem_req and imem_addr stay fixed until
  // that transfer; imem_ready is ignored while imem_req is 0.

  fetch_state_t          state, state_d;
  logic [DATA_WIDTH-1:0] pc, pc_d;
  logic [DATA_WIDTH-1:0] req_addr, req_addr_d;
  logic [DATA_WIDTH-1:0] instr_buf, instr_buf_d;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] pc_next_seq;

  assign target      = {PCTargetE[DATA_WIDTH-1:2], 2'b00};
  assign pc_next_seq = pc + DATA_WIDTH'(PC_INCR);

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    req_addr_d  = req_addr;
    instr_buf_d = instr_buf;
    unique case (state)
      IDLE: begin
        state_d = REQ;
        if (PCSrcE) begin
          pc_d       = target;
          req_addr_d = target;
        end
      end
      REQ: begin
        if (imem_ready && !PCSrcE) begin
          instr_buf_d = imem_rdata;
          state_d     = HOLD;
        end else if (imem_ready && PCSrcE) begin
          pc_d       = target;
          req_addr_d = target;
        end else if (PCSrcE) begin
          // Request in flight cannot be re-addressed; remember where to go next.
          pc_d    = target;
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ready) begin
          state_d    = REQ;
          pc_d       = PCSrcE ? target : pc;
          req_addr_d = PCSrcE ? target : pc;
        end else if (PCSrcE) begin
          pc_d = target;
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pc_d       = target;
          req_addr_d = target;
          state_d    = REQ;
        end else if (!stallF) begin
          pc_d       = pc_next_seq;
          req_addr_d = pc_next_seq;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      instr_buf <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      req_addr  <= req_addr_d;
      instr_buf <= instr_buf_d;
    end
  end

  assign PCounterF   = pc;
  assign PCPlus4F    = pc_next_seq;
  assign imem_addr   = req_addr;
  assign InstrF      = instr_buf;
  assign imem_req    = (state == REQ) || (state == DROP);
  assign InstrValidF = (state == HOLD);
  assign fetch_busy  = !InstrValidF;
  assign state_dbg   = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change and outputs are checked on the
// falling edge, so the rising edge always sees settled stimulus.
module tb_fetch_stage;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic        clk;
  logic        rst;
  logic        stallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PCounterF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        fetch_busy;
  logic [1:0]  state_dbg;

  int n_checks;
  int n_errors;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .PCounterF   (PCounterF),
    .PCPlus4F    (PCPlus4F),
    .InstrF      (InstrF),
    .InstrValidF (InstrValidF),
    .fetch_busy  (fetch_busy),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // REQ -> HOLD with a one-cycle memory response
  task automatic complete(input logic [31:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    step();
    imem_ready = 1'b0;
  endtask

  // HOLD -> REQ on the sequential path
  task automatic advance();
    stallF = 1'b0;
    PCSrcE = 1'b0;
    step();
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    stallF     = 1'b0;
    PCSrcE     = 1'b0;
    PCTargetE  = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;

    // reset values
    #12;
    check("rst_req",    {31'b0, imem_req},    32'h0);
    check("rst_valid",  {31'b0, InstrValidF}, 32'h0);
    check("rst_instr",  InstrF,               32'h0);
    check("rst_pc",     PCounterF,            32'h0);
    check("rst_pc4",    PCPlus4F,             32'h4);
    check("rst_busy",   {31'b0, fetch_busy},  32'h1);
    check("rst_state",  {30'b0, state_dbg},   {30'b0, S_IDLE});
    step();
    rst = 1'b1;

    // zero-wait memory: REQ/HOLD alternation at 0x0, 0x4, 0x8
    imem_ready = 1'b1;
    imem_rdata = 32'hA000_0000;
    step();
    check("zw_req0",   {31'b0, imem_req}, 32'h1);
    check("zw_addr0",  imem_addr,         32'h0);
    check("zw_pc4_0",  PCPlus4F,          32'h4);
    check("zw_busy0",  {31'b0, fetch_busy}, 32'h1);
    step();
    check("zw_valid0", {31'b0, InstrValidF}, 32'h1);
    check("zw_instr0", InstrF,            32'hA000_0000);
    check("zw_req_h0", {31'b0, imem_req}, 32'h0);
    imem_rdata = 32'hA000_0004;
    step();
    check("zw_addr1",  imem_addr,         32'h4);
    check("zw_valid1", {31'b0, InstrValidF}, 32'h0);
    step();
    check("zw_instr1", InstrF,            32'hA000_0004);
    check("zw_pc1",    PCounterF,         32'h4);
    imem_rdata = 32'hA000_0008;
    step();
    check("zw_addr2",  imem_addr,         32'h8);
    step();
    check("zw_instr2", InstrF,            32'hA000_0008);
    step();
    step();
    imem_ready = 1'b0;
    step();

    // three-cycle memory latency at 0x10
    for (int i = 0; i < 3; i++) begin
      check("lat_req",  {31'b0, imem_req},   32'h1);
      check("lat_addr", imem_addr,           32'h10);
      check("lat_busy", {31'b0, fetch_busy}, 32'h1);
      if (i < 2) step();
    end
    complete(32'h0050_0093);
    check("lat_valid", {31'b0, InstrValidF}, 32'h1);
    check("lat_instr", InstrF,               32'h0050_0093);

    // walk to 0x20 and stall there for 4 cycles
    advance(); complete(32'h14);
    advance(); complete(32'h18);
    advance(); complete(32'h1C);
    advance();
    check("walk_addr20", imem_addr, 32'h20);
    complete(32'h2000_DEAD);
    stallF = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_pc",    PCounterF,             32'h20);
      check("stall_instr", InstrF,                32'h2000_DEAD);
      check("stall_valid", {31'b0, InstrValidF},  32'h1);
      check("stall_req",   {31'b0, imem_req},     32'h0);
    end
    advance();
    check("unstall_addr", imem_addr, 32'h24);

    // redirect while the 0x30 request is pending
    complete(32'h24);
    advance(); complete(32'h28);
    advance(); complete(32'h2C);
    advance();
    check("pend_addr", imem_addr, 32'h30);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0103;
    step();
    PCSrcE = 1'b0;
    check("drop_state", {30'b0, state_dbg}, {30'b0, S_DROP});
    check("drop_addr",  imem_addr,          32'h30);
    check("drop_req",   {31'b0, imem_req},  32'h1);
    check("drop_pc",    PCounterF,          32'h100);
    step();
    check("drop_addr2", imem_addr,          32'h30);
    check("drop_valid", {31'b0, InstrValidF}, 32'h0);
    complete(32'hBAD0_0030);
    check("drop_done_state", {30'b0, state_dbg}, {30'b0, S_REQ});
    check("drop_done_addr",  imem_addr,          32'h100);
    check("drop_done_valid", {31'b0, InstrValidF}, 32'h0);

    // redirect beats stall in HOLD
    complete(32'h0000_0011);
    stallF    = 1'b1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0200;
    step();
    stallF = 1'b0;
    PCSrcE = 1'b0;
    check("prio_state", {30'b0, state_dbg}, {30'b0, S_REQ});
    check("prio_addr",  imem_addr,          32'h200);

    // redirect coincident with ready in REQ drops the data
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0300;
    complete(32'h0000_0055);
    PCSrcE = 1'b0;
    check("rr_state", {30'b0, state_dbg},   {30'b0, S_REQ});
    check("rr_addr",  imem_addr,            32'h300);
    check("rr_pc",    PCounterF,            32'h300);
    check("rr_instr", InstrF,               32'h0000_0011);
    check("rr_valid", {31'b0, InstrValidF}, 32'h0);

    // asynchronous reset while waiting on memory
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_req",   {31'b0, imem_req},   32'h0);
    check("arst_pc",    PCounterF,           32'h0);
    check("arst_pc4",   PCPlus4F,            32'h4);
    check("arst_instr", InstrF,              32'h0);
    check("arst_busy",  {31'b0, fetch_busy}, 32'h1);
    check("arst_state", {30'b0, state_dbg},  {30'b0, S_IDLE});
    step();
    rst = 1'b1;

    // redirect from IDLE near the top of memory, then wrap to 0
    PCSrcE    = 1'b1;
    PCTargetE = 32'hFFFF_FFFF;
    step();
    PCSrcE = 1'b0;
    check("wrap_pc",   PCounterF, 32'hFFFF_FFFC);
    check("wrap_pc4",  PCPlus4F,  32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    complete(32'h0000_0077);
    check("wrap_instr", InstrF, 32'h0000_0077);
    advance();
    check("wrap_next_addr", imem_addr, 32'h0);
    check("wrap_next_pc",   PCounterF, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
